// File: rtl/q_learning_pkg.sv
// rtl/q_learning_pkg.sv - shared widths and sequencer state encoding for the Q-learning datapath
package q_learning_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 8;
   localparam int N_ACT_DEF  = 9;
   localparam int RD_LAT_DEF = 1;
   localparam int ACT_W      = 4;

   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_NEXT,
      ST_RD_CUR,
      ST_CALC,
      ST_WRITE,
      ST_RESP
   } seq_state_t;

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - binary action index to one-hot enable decoder
module decoder
   import q_learning_pkg::*;
#(
   parameter int N_OUT = N_ACT_DEF
)(
   input  logic [ACT_W-1:0] sel,
   output logic [N_OUT-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_OUT; i++) begin
         onehot[i] = (sel == ACT_W'(i));
      end
   end

endmodule

// File: rtl/q_update_sequencer.sv
// rtl/q_update_sequencer.sv - sequences one Q-table read/update/write per accepted request
module q_update_sequencer
   import q_learning_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_ACT  = N_ACT_DEF,
   parameter int RD_LAT = RD_LAT_DEF
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_state,
   input  logic [ADDR_W-1:0] req_next_state,
   input  logic [3:0]        req_action,
   input  logic [DATA_W-1:0] req_reward,
   input  logic              req_terminal,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [3:0]        rd_action,
   input  logic [DATA_W-1:0] q_max_in,
   input  logic [DATA_W-1:0] q_sa_in,
   output logic [DATA_W-1:0] upd_q,
   output logic [DATA_W-1:0] upd_max,
   output logic [DATA_W-1:0] upd_reward,
   input  logic [DATA_W-1:0] q_new_in,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [N_ACT-1:0]  wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_q_new,
   output logic              rsp_err,
   output logic              busy,
   output logic [15:0]       update_count
);

   seq_state_t        state, state_nxt;
   logic [7:0]        wait_cnt;
   logic [ADDR_W-1:0] s_reg, sn_reg;
   logic [ACT_W-1:0]  a_reg;
   logic [DATA_W-1:0] reward_reg, max_reg, qsa_reg, qnew_reg, rsp_q_reg;
   logic              err_reg;
   logic [15:0]       count_reg;
   logic [N_ACT-1:0]  dec_onehot;

   logic accept, illegal, rd_next_done, rd_cur_done;

   assign accept       = (state == ST_IDLE) && req_valid;
   assign illegal      = 32'(req_action) >= N_ACT;
   // RAM read takes RD_LAT cycles; the action mux adds one more stage.
   assign rd_next_done = (state == ST_RD_NEXT) && (wait_cnt == 8'(RD_LAT));
   assign rd_cur_done  = (state == ST_RD_CUR)  && (wait_cnt == 8'(RD_LAT + 1));

   decoder #(.N_OUT(N_ACT)) u_decoder (
      .sel    (a_reg),
      .onehot (dec_onehot)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      busy      = 1'b1;
      rd_addr   = '0;
      rd_action = '0;
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      rsp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               if (illegal) begin
                  state_nxt = ST_RESP;
               end else if (req_terminal) begin
                  state_nxt = ST_RD_CUR;
               end else begin
                  state_nxt = ST_RD_NEXT;
               end
            end
         end
         ST_RD_NEXT: begin
            rd_addr = sn_reg;
            if (rd_next_done) state_nxt = ST_RD_CUR;
         end
         ST_RD_CUR: begin
            rd_addr   = s_reg;
            rd_action = a_reg;
            if (rd_cur_done) state_nxt = ST_CALC;
         end
         ST_CALC: begin
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            wr_en     = dec_onehot;
            wr_addr   = s_reg;
            wr_data   = qnew_reg;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wait_cnt   <= '0;
         s_reg      <= '0;
         sn_reg     <= '0;
         a_reg      <= '0;
         reward_reg <= '0;
         max_reg    <= '0;
         qsa_reg    <= '0;
         qnew_reg   <= '0;
         rsp_q_reg  <= '0;
         err_reg    <= 1'b0;
         count_reg  <= '0;
      end else begin
         if ((state == ST_RD_NEXT || state == ST_RD_CUR) && !rd_next_done && !rd_cur_done) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end

         if (accept) begin
            s_reg      <= req_state;
            sn_reg     <= req_next_state;
            a_reg      <= req_action[ACT_W-1:0];
            reward_reg <= req_reward;
            // Cleared here so a terminal request, which skips RD_NEXT, sees max Q = 0.
            max_reg    <= '0;
            if (illegal) begin
               rsp_q_reg <= '0;
               err_reg   <= 1'b1;
            end
         end

         if (rd_next_done) max_reg <= q_max_in;
         if (rd_cur_done)  qsa_reg <= q_sa_in;
         if (state == ST_CALC) qnew_reg <= q_new_in;

         if (state == ST_WRITE) begin
            rsp_q_reg <= qnew_reg;
            err_reg   <= 1'b0;
            if (count_reg != COUNT_MAX) count_reg <= count_reg + 16'd1;
         end
      end
   end

   assign upd_q        = qsa_reg;
   assign upd_max      = max_reg;
   assign upd_reward   = reward_reg;
   assign rsp_q_new    = rsp_q_reg;
   assign rsp_err      = err_reg;
   assign update_count = count_reg;

endmodule

// File: tb/tb_q_update_sequencer.sv
// tb/tb_q_update_sequencer.sv - self-checking bench with Q-table RAM, updater and scoreboard models
module tb_q_update_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_terminal;
   logic [17:0] req_state, req_next_state, rd_addr, wr_addr;
   logic [3:0]  req_action, rd_action;
   logic [7:0]  req_reward, q_max_in, q_sa_in, upd_q, upd_max, upd_reward, q_new_in, wr_data, rsp_q_new;
   logic [8:0]  wr_en;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [15:0] update_count;

   q_update_sequencer dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
      .req_next_state(req_next_state), .req_action(req_action), .req_reward(req_reward),
      .req_terminal(req_terminal), .rd_addr(rd_addr), .rd_action(rd_action),
      .q_max_in(q_max_in), .q_sa_in(q_sa_in), .upd_q(upd_q), .upd_max(upd_max),
      .upd_reward(upd_reward), .q_new_in(q_new_in), .wr_addr(wr_addr), .wr_en(wr_en),
      .wr_data(wr_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_q_new(rsp_q_new), .rsp_err(rsp_err), .busy(busy), .update_count(update_count)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Environment RAM (written only by the DUT) and the scoreboard's own table.
   logic [7:0] ram_tab [int];
   logic [7:0] ref_tab [int];
   int         ref_count = 0;
   logic [7:0] sa_d1;

   function automatic int key(input logic [17:0] s, input int a);
      return int'(s) * 16 + a;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [17:0] s, input int a);
      int k = key(s, a);
      return ram_tab.exists(k) ? ram_tab[k] : 8'd0;
   endfunction

   function automatic logic [7:0] ram_row_max(input logic [17:0] s);
      logic [7:0] m = 8'd0;
      for (int i = 0; i < 9; i++) if (ram_rd(s, i) > m) m = ram_rd(s, i);
      return m;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [17:0] s, input int a);
      int k = key(s, a);
      return ref_tab.exists(k) ? ref_tab[k] : 8'd0;
   endfunction

   // Updater: alpha = 1/3, gamma = 1/2, clamped to 0..255.
   function automatic logic [7:0] upd_fn(input logic [7:0] q, input logic [7:0] m, input logic [7:0] r);
      int t = int'(r) + int'(m) / 2;
      int n = int'(q) + (t - int'(q)) / 3;
      if (n < 0) n = 0;
      if (n > 255) n = 255;
      return 8'(n);
   endfunction

   assign q_new_in = upd_fn(upd_q, upd_max, upd_reward);

   always @(posedge clock) begin
      q_max_in <= ram_row_max(rd_addr);
      sa_d1    <= ram_rd(rd_addr, int'(rd_action));
      q_sa_in  <= sa_d1;
   end

   always @(posedge clock) begin
      for (int i = 0; i < 9; i++) if (wr_en[i]) ram_tab[key(wr_addr, i)] = wr_data;
   end

   task automatic set_both(input logic [17:0] s, input int a, input logic [7:0] v);
      ram_tab[key(s, a)] = v;
      ref_tab[key(s, a)] = v;
   endtask

   task automatic model_req(input logic [17:0] s, input logic [17:0] sn, input logic [3:0] a,
                            input logic [7:0] r, input logic t,
                            output logic [7:0] e_q, output logic [7:0] e_max, output logic [7:0] e_new,
                            output logic e_err, output int e_lat);
      if (a >= 4'd9) begin
         e_err = 1'b1; e_new = 8'd0; e_q = 8'd0; e_max = 8'd0; e_lat = 1;
      end else begin
         e_err = 1'b0;
         e_max = 8'd0;
         if (!t) for (int i = 0; i < 9; i++) if (ref_rd(sn, i) > e_max) e_max = ref_rd(sn, i);
         e_q   = ref_rd(s, int'(a));
         e_new = upd_fn(e_q, e_max, r);
         ref_tab[key(s, int'(a))] = e_new;
         if (ref_count < 65535) ref_count++;
         e_lat = t ? 6 : 8;
      end
   endtask

   logic [17:0] tr_rd_addr [0:31];
   logic [7:0]  tr_upd_q   [0:31];
   logic [7:0]  tr_upd_max [0:31];
   int          obs_lat, obs_nwr, obs_wr_cyc, obs_wait;
   logic [8:0]  obs_wr_en;
   logic [17:0] obs_wr_addr;
   logic [7:0]  obs_wr_data;
   int          hold_bad;
   logic        post_valid, post_ready;

   // Called at a negedge; returns at the negedge of the first rsp_valid cycle (or budget).
   task automatic drive_req(input logic [17:0] s, input logic [17:0] sn, input logic [3:0] a,
                            input logic [7:0] r, input logic t);
      req_state = s; req_next_state = sn; req_action = a; req_reward = r; req_terminal = t;
      req_valid = 1'b1;
      obs_wait = 0;
      while (req_ready !== 1'b1 && obs_wait < 20) begin
         @(negedge clock);
         obs_wait++;
      end
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      obs_lat = -1; obs_nwr = 0; obs_wr_cyc = -1;
      obs_wr_en = '0; obs_wr_addr = '0; obs_wr_data = '0;
      for (int c = 1; c < 32; c++) begin
         tr_rd_addr[c] = rd_addr; tr_upd_q[c] = upd_q; tr_upd_max[c] = upd_max;
         if (wr_en !== 9'd0) begin
            obs_nwr++; obs_wr_cyc = c; obs_wr_en = wr_en; obs_wr_addr = wr_addr; obs_wr_data = wr_data;
         end
         if (rsp_valid === 1'b1) begin
            obs_lat = c;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic finish_rsp(input int hold);
      logic [7:0] q0 = rsp_q_new;
      logic       e0 = rsp_err;
      hold_bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b1 || rsp_q_new !== q0 || rsp_err !== e0 || req_ready !== 1'b0) hold_bad++;
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rsp_ready = 1'b0;
      post_valid = rsp_valid;
      post_ready = req_ready;
   endtask

   logic [7:0] e_q, e_max, e_new;
   logic       e_err;
   int         e_lat;

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_state = '0; req_next_state = '0; req_action = '0; req_reward = '0; req_terminal = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      n_cmp++;
      if ({rd_addr, rd_action, upd_q, upd_max, upd_reward, wr_addr, wr_en, wr_data,
           rsp_valid, rsp_q_new, rsp_err, busy, update_count} !== '0) begin
         n_bad++; $display("FAIL reset_outputs not all zero rsp_valid=%b busy=%b cnt=%0d", rsp_valid, busy, update_count);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_normal();
      for (int i = 0; i < 9; i++) set_both(18'h00005, i, 8'(i * 2));
      set_both(18'h00005, 6, 8'd20);
      set_both(18'h00001, 4, 8'd8);
      model_req(18'h00001, 18'h00005, 4'd4, 8'd10, 1'b0, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h00001, 18'h00005, 4'd4, 8'd10, 1'b0);
      n_cmp++;
      if (e_new !== 8'd12) begin n_bad++; $display("FAIL normal_model got %0d exp 12", e_new); end
      n_cmp++;
      if (obs_lat !== 8) begin n_bad++; $display("FAIL normal_latency got %0d exp 8", obs_lat); end
      n_cmp++;
      if ({tr_rd_addr[1], tr_rd_addr[2], tr_rd_addr[3], tr_rd_addr[4], tr_rd_addr[5]} !==
          {18'h5, 18'h5, 18'h1, 18'h1, 18'h1}) begin
         n_bad++; $display("FAIL normal_rd_addr got %h %h %h %h %h exp 5 5 1 1 1",
                           tr_rd_addr[1], tr_rd_addr[2], tr_rd_addr[3], tr_rd_addr[4], tr_rd_addr[5]);
      end
      n_cmp++;
      if (tr_upd_max[6] !== 8'd20 || tr_upd_q[6] !== 8'd8) begin
         n_bad++; $display("FAIL normal_operands got max=%0d q=%0d exp 20 8", tr_upd_max[6], tr_upd_q[6]);
      end
      n_cmp++;
      if (obs_nwr !== 1 || obs_wr_cyc !== 7 || obs_wr_en !== 9'b000010000) begin
         n_bad++; $display("FAIL normal_wr_en got n=%0d cyc=%0d en=%b exp 1 7 000010000", obs_nwr, obs_wr_cyc, obs_wr_en);
      end
      n_cmp++;
      if (obs_wr_addr !== 18'h1 || obs_wr_data !== e_new) begin
         n_bad++; $display("FAIL normal_wr_data got addr=%h data=%0d exp 1 %0d", obs_wr_addr, obs_wr_data, e_new);
      end
      n_cmp++;
      if (rsp_q_new !== e_new || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL normal_rsp got q=%0d err=%b exp %0d 0", rsp_q_new, rsp_err, e_new);
      end
      finish_rsp(0);
      n_cmp++;
      if (update_count !== 16'(ref_count) || post_valid !== 1'b0 || post_ready !== 1'b1) begin
         n_bad++; $display("FAIL normal_after got cnt=%0d valid=%b ready=%b exp %0d 0 1", update_count, post_valid, post_ready, ref_count);
      end
   endtask

   task automatic test_terminal();
      int seen_sn = 0;
      set_both(18'h00001, 0, 8'd30);
      model_req(18'h00001, 18'h00005, 4'd0, 8'd7, 1'b1, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h00001, 18'h00005, 4'd0, 8'd7, 1'b1);
      for (int c = 1; c <= obs_lat; c++) if (tr_rd_addr[c] === 18'h5) seen_sn++;
      n_cmp++;
      if (obs_lat !== 6) begin n_bad++; $display("FAIL term_latency got %0d exp 6", obs_lat); end
      n_cmp++;
      if (seen_sn !== 0) begin n_bad++; $display("FAIL term_sn_read got %0d cycles exp 0", seen_sn); end
      n_cmp++;
      if (tr_upd_max[4] !== 8'd0 || tr_upd_q[4] !== 8'd30) begin
         n_bad++; $display("FAIL term_operands got max=%0d q=%0d exp 0 30", tr_upd_max[4], tr_upd_q[4]);
      end
      n_cmp++;
      if (obs_nwr !== 1 || obs_wr_cyc !== 5 || obs_wr_en !== 9'b000000001 || obs_wr_data !== e_new) begin
         n_bad++; $display("FAIL term_write got n=%0d cyc=%0d en=%b data=%0d exp 1 5 000000001 %0d",
                           obs_nwr, obs_wr_cyc, obs_wr_en, obs_wr_data, e_new);
      end
      finish_rsp(0);
   endtask

   task automatic test_illegal();
      logic [15:0] cnt0 = update_count;
      model_req(18'h00001, 18'h00005, 4'd9, 8'd3, 1'b0, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h00001, 18'h00005, 4'd9, 8'd3, 1'b0);
      n_cmp++;
      if (obs_lat !== 1 || rsp_err !== 1'b1 || rsp_q_new !== 8'd0) begin
         n_bad++; $display("FAIL illegal_rsp got lat=%0d err=%b q=%0d exp 1 1 0", obs_lat, rsp_err, rsp_q_new);
      end
      finish_rsp(2);
      n_cmp++;
      if (obs_nwr !== 0 || update_count !== cnt0 || hold_bad !== 0) begin
         n_bad++; $display("FAIL illegal_nowrite got nwr=%0d cnt=%0d hold_bad=%0d exp 0 %0d 0", obs_nwr, update_count, hold_bad, cnt0);
      end
   endtask

   task automatic test_backpressure();
      model_req(18'h00005, 18'h00001, 4'd2, 8'd40, 1'b0, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h00005, 18'h00001, 4'd2, 8'd40, 1'b0);
      req_state = 18'h00001; req_next_state = 18'h00005; req_action = 4'd8;
      req_reward = 8'd5; req_terminal = 1'b0; req_valid = 1'b1;
      finish_rsp(5);
      n_cmp++;
      if (hold_bad !== 0 || rsp_q_new !== e_new) begin
         n_bad++; $display("FAIL bp_hold got bad=%0d q=%0d exp 0 %0d", hold_bad, rsp_q_new, e_new);
      end
      model_req(18'h00001, 18'h00005, 4'd8, 8'd5, 1'b0, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h00001, 18'h00005, 4'd8, 8'd5, 1'b0);
      n_cmp++;
      if (obs_wait !== 0 || obs_lat !== 8 || rsp_q_new !== e_new) begin
         n_bad++; $display("FAIL bp_second got wait=%0d lat=%0d q=%0d exp 0 8 %0d", obs_wait, obs_lat, rsp_q_new, e_new);
      end
      finish_rsp(0);
   endtask

   task automatic test_reset_mid();
      int wr_seen = 0;
      req_state = 18'h00001; req_next_state = 18'h00005; req_action = 4'd3;
      req_reward = 8'd9; req_terminal = 1'b0; req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         if (wr_en !== 9'd0) wr_seen++;
         if (c < 3) @(negedge clock);
      end
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      if (wr_en !== 9'd0) wr_seen++;
      n_cmp++;
      if (req_ready !== 1'b1 || {rd_addr, rd_action, upd_q, upd_max, upd_reward, wr_addr, wr_en,
                                 wr_data, rsp_valid, rsp_q_new, rsp_err, busy, update_count} !== '0) begin
         n_bad++; $display("FAIL rstmid_outputs got ready=%b busy=%b cnt=%0d rd_addr=%h", req_ready, busy, update_count, rd_addr);
      end
      reset_n = 1'b1;
      ref_count = 0;
      repeat (3) begin
         @(negedge clock);
         if (wr_en !== 9'd0) wr_seen++;
      end
      n_cmp++;
      if (wr_seen !== 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_after got wr=%0d ready=%b busy=%b exp 0 1 0", wr_seen, req_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] first_wr;
      model_req(18'h2A2A1, 18'h00005, 4'd7, 8'd60, 1'b0, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h2A2A1, 18'h00005, 4'd7, 8'd60, 1'b0);
      first_wr = obs_wr_data;
      n_cmp++;
      if (first_wr !== e_new) begin n_bad++; $display("FAIL b2b_first got %0d exp %0d", first_wr, e_new); end
      finish_rsp(0);
      model_req(18'h2A2A1, 18'h00001, 4'd7, 8'd60, 1'b0, e_q, e_max, e_new, e_err, e_lat);
      drive_req(18'h2A2A1, 18'h00001, 4'd7, 8'd60, 1'b0);
      n_cmp++;
      if (tr_upd_q[6] !== first_wr || rsp_q_new !== e_new) begin
         n_bad++; $display("FAIL b2b_second got upd_q=%0d q=%0d exp %0d %0d", tr_upd_q[6], rsp_q_new, first_wr, e_new);
      end
      finish_rsp(0);
      n_cmp++;
      if (update_count !== 16'(ref_count)) begin
         n_bad++; $display("FAIL b2b_count got %0d exp %0d", update_count, ref_count);
      end
   endtask

   task automatic test_random();
      logic [17:0] pool [4] = '{18'h00001, 18'h00005, 18'h2A2A1, 18'h3FFFF};
      for (int p = 0; p < 4; p++) for (int i = 0; i < 9; i++) set_both(pool[p], i, 8'($urandom_range(0, 255)));
      for (int n = 0; n < 40; n++) begin
         logic [17:0] s  = pool[$urandom_range(0, 3)];
         logic [17:0] sn = pool[$urandom_range(0, 3)];
         logic [3:0]  a  = ($urandom_range(0, 9) == 0) ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
         logic [7:0]  r  = 8'($urandom_range(0, 255));
         logic        t  = ($urandom_range(0, 3) == 0);
         int          hold = $urandom_range(0, 3);
         model_req(s, sn, a, r, t, e_q, e_max, e_new, e_err, e_lat);
         drive_req(s, sn, a, r, t);
         n_cmp++;
         if (obs_lat !== e_lat || rsp_q_new !== e_new || rsp_err !== e_err) begin
            n_bad++; $display("FAIL rand_rsp[%0d] got lat=%0d q=%0d err=%b exp %0d %0d %b",
                              n, obs_lat, rsp_q_new, rsp_err, e_lat, e_new, e_err);
         end
         if (!e_err) begin
            n_cmp++;
            if (tr_upd_q[e_lat - 2] !== e_q || tr_upd_max[e_lat - 2] !== e_max) begin
               n_bad++; $display("FAIL rand_ops[%0d] got q=%0d max=%0d exp %0d %0d",
                                 n, tr_upd_q[e_lat - 2], tr_upd_max[e_lat - 2], e_q, e_max);
            end
         end
         n_cmp++;
         if (obs_nwr !== (e_err ? 0 : 1) || (!e_err && (obs_wr_addr !== s || obs_wr_en !== 9'(1 << a)))) begin
            n_bad++; $display("FAIL rand_wr[%0d] got n=%0d addr=%h en=%b", n, obs_nwr, obs_wr_addr, obs_wr_en);
         end
         finish_rsp(hold);
         n_cmp++;
         if (hold_bad !== 0 || post_valid !== 1'b0 || update_count !== 16'(ref_count)) begin
            n_bad++; $display("FAIL rand_hs[%0d] got bad=%0d valid=%b cnt=%0d exp 0 0 %0d",
                              n, hold_bad, post_valid, update_count, ref_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_terminal();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
